// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller.
package sobel_pkg;

  localparam int IMG_W_MAX_DEF = 1024;
  localparam int IMG_H_MAX_DEF = 1024;
  localparam int AW = $clog2(IMG_W_MAX_DEF);
  localparam int DW = 11;

  localparam logic [DW-1:0] MIN_DIM = 11'd3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/sobel_raster_cnt.sv
// Raster column/row counters with mod-3 line-buffer rotation.
module sobel_raster_cnt
  import sobel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [DW-1:0] width_i,
  input  logic [DW-1:0] height_i,
  output logic [DW-1:0] col_o,
  output logic [DW-1:0] row_o,
  output logic [1:0]    sel_o,
  output logic          last_col_o,
  output logic          last_px_o
);

  logic [DW-1:0] col_q, col_d;
  logic [DW-1:0] row_q, row_d;
  logic [1:0]    sel_q, sel_d;

  assign last_col_o = (col_q == width_i - 11'd1);
  assign last_px_o  = last_col_o
                   && (row_q == height_i - 11'd1);

  // The final pixel clears instead of wrapping so row never reaches height.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    if (clr_i || (adv_i && last_px_o)) begin
      col_d = '0;
      row_d = '0;
      sel_d = '0;
    end else if (adv_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + 11'd1;
        sel_d = (sel_q == 2'd2) ? 2'd0
                                : sel_q + 2'd1;
      end else begin
        col_d = col_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      sel_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= sel_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame FSM and registered line-buffer / window strobes for the Sobel core.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W_MAX = IMG_W_MAX_DEF,
  parameter int IMG_H_MAX = IMG_H_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [DW-1:0] width_i,
  input  logic [DW-1:0] height_i,
  input  logic          done_i,
  output logic          lb_wr_en_o,
  output logic [1:0]    lb_sel_o,
  output logic [AW-1:0] lb_addr_o,
  output logic          shift_en_o,
  output logic          win_valid_o,
  output logic [DW-1:0] row_o,
  output logic [DW-1:0] col_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          cfg_err_o
);

  localparam logic [DW-1:0] W_MAX = DW'(IMG_W_MAX);
  localparam logic [DW-1:0] H_MAX = DW'(IMG_H_MAX);

  state_e state_q, state_d;

  logic [DW-1:0] w_q, w_d;
  logic [DW-1:0] h_q, h_d;
  logic          pix_q, pix_d;
  logic          win_q, win_d;
  logic          err_q, err_d;
  logic [1:0]    sel_q, sel_d;
  logic [DW-1:0] col_q, col_d;
  logic [DW-1:0] row_q, row_d;

  logic          size_ok;
  logic          start_ok;
  logic          accept;
  logic [DW-1:0] cnt_col;
  logic [DW-1:0] cnt_row;
  logic [1:0]    cnt_sel;
  logic          last_col;
  logic          last_px;

  assign size_ok = (width_i >= MIN_DIM)
                && (width_i <= W_MAX)
                && (height_i >= MIN_DIM)
                && (height_i <= H_MAX);

  assign start_ok = start_i && (state_q == IDLE)
                 && size_ok;
  assign accept = done_i
               && ((state_q == FILL) || (state_q == RUN));

  sobel_raster_cnt u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_ok),
    .adv_i      (accept),
    .width_i    (w_q),
    .height_i   (h_q),
    .col_o      (cnt_col),
    .row_o      (cnt_row),
    .sel_o      (cnt_sel),
    .last_col_o (last_col),
    .last_px_o  (last_px)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = FILL;
      FILL: if (accept && last_col
                && cnt_row == 11'd1) state_d = RUN;
      RUN:  if (accept && last_px) state_d = DONE;
      DONE: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == FILL)
                || (state_q == RUN);
    frame_done_o = (state_q == DONE);
  end

  // Pixel outputs describe the pixel accepted on the previous edge.
  always_comb begin
    w_d   = start_ok ? width_i : w_q;
    h_d   = start_ok ? height_i : h_q;
    err_d = start_i && (state_q == IDLE) && !size_ok;
    pix_d = accept;
    win_d = accept && (state_q == RUN)
         && (cnt_col >= 11'd2);
    sel_d = accept ? cnt_sel : sel_q;
    col_d = accept ? cnt_col : col_q;
    row_d = accept ? cnt_row : row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      h_q   <= '0;
      err_q <= 1'b0;
      pix_q <= 1'b0;
      win_q <= 1'b0;
      sel_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      w_q   <= w_d;
      h_q   <= h_d;
      err_q <= err_d;
      pix_q <= pix_d;
      win_q <= win_d;
      sel_q <= sel_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign lb_wr_en_o  = pix_q;
  assign shift_en_o  = pix_q;
  assign win_valid_o = win_q;
  assign cfg_err_o   = err_q;
  assign lb_sel_o    = sel_q;
  assign lb_addr_o   = col_q[AW-1:0];
  assign col_o       = col_q;
  assign row_o       = row_q;

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter IMG_W_MAX, default 1024, maximum image width in pixels; line-buffer address width AW = clog2(IMG_W_MAX) = 10.
REQ-002 Parameter IMG_H_MAX, default 1024, maximum image height in rows.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  one-cycle pulse; starts a frame with the current width_i/height_i.
REQ-006 width_i  input  11  frame width in pixels; sampled on accepted start_i.
REQ-007 height_i  input  11  frame height in rows; sampled on accepted start_i.
REQ-008 done_i  input  1  pixel strobe from the grayscale stage; one grayscale pixel per high cycle, raster order.
REQ-009 lb_wr_en_o  output  1  line-buffer write enable for the current pixel.
REQ-010 lb_sel_o  output  2  index (0..2) of the line buffer being written.
REQ-011 lb_addr_o  output  AW  line-buffer write/read address (current column).
REQ-012 shift_en_o  output  1  advance the 3x3 window shift registers by one column.
REQ-013 win_valid_o  output  1  the 3x3 window is complete; the Sobel core computes this cycle.
REQ-014 row_o / col_o  output  11 each  coordinates of the current pixel.
REQ-015 busy_o  output  1  high from accepted start_i until frame_done_o.
REQ-016 frame_done_o  output  1  one-cycle pulse after the last pixel of the frame.
REQ-017 cfg_err_o  output  1  one-cycle pulse when start_i is rejected for an illegal size.

Function
REQ-018 FSM states SHALL be IDLE, FILL, RUN and DONE.
REQ-019 IDLE: start_i with 3<=width_i<=IMG_W_MAX and 3<=height_i<=IMG_H_MAX -> latch size, clear counters, go to FILL; otherwise pulse cfg_err_o and remain in IDLE.
REQ-020 start_i outside IDLE SHALL be ignored; done_i in IDLE or DONE SHALL be ignored (no output activity).
REQ-021 Each accepted done_i SHALL produce registered outputs one cycle later: lb_wr_en_o=1, shift_en_o=1, lb_addr_o=col, lb_sel_o=current buffer, row_o/col_o=pixel coordinates.
REQ-022 col SHALL increment per accepted pixel and wrap from width-1 to 0; on wrap, row increments and lb_sel rotates 0->1->2->0.
REQ-023 FILL SHALL cover rows 0 and 1; when row reaches 2 at col 0, the FSM transitions to RUN.
REQ-024 win_valid_o SHALL be 1 only in RUN for pixels with col>=2; the window center is at (row-1, col-1).
REQ-025 Accepting pixel (height-1, width-1) SHALL move the FSM to DONE; DONE pulses frame_done_o for one cycle, drops busy_o the same cycle, and returns to IDLE.
REQ-026 Gaps in done_i (strobe low) SHALL hold all counters and deassert lb_wr_en_o, shift_en_o and win_valid_o.
REQ-027 The counters SHALL never exceed the latched width-1 or height-1; no pixel beyond the frame is accepted.

Reset
REQ-028 On rst_n low, regardless of state or mid-frame activity: FSM=IDLE, all counters=0, lb_sel_o=0, lb_addr_o=0, row_o=col_o=0, and every 1-bit output=0.
REQ-029 After rst_n deasserts, the block SHALL need a fresh start_i; pixels from an interrupted frame are discarded.

Structure
REQ-030 A shared package sobel_pkg SHALL hold the FSM state enum, IMG_W_MAX/IMG_H_MAX defaults, AW, and the minimum dimension constant (3).
REQ-031 One sub-module, sobel_raster_cnt (col/row counters with wrap and mod-3 buffer rotation), SHALL be instantiated; the FSM and output registers stay in the top.

Verification
REQ-032 width=4, height=3, 12 back-to-back strobes -> win_valid_o high exactly 2 cycles (row 2, col 2 and 3); frame_done_o pulses one cycle after the 12th accepted pixel.
REQ-033 width=2, height=8 start -> cfg_err_o pulse, busy_o stays 0, later done_i ignored.
REQ-034 width=5, height=4 with done_i toggling 1/0 -> counters hold on low cycles; lb_sel_o sequence 0,1,2,0 per row; 20 lb_wr_en_o pulses in total.
REQ-035 rst_n pulled low at row 2, col 1 of a 6x6 frame -> all outputs 0 asynchronously; a new 3x3 frame then completes with exactly 1 win_valid_o.
REQ-036 start_i re-asserted mid-frame with width=10 -> ignored; the frame finishes with the original size.
